vga_strip_timing: RTL and testbench

- Pixel-rate raster timing generator for the 640x480 VGA path.
- Produces the sync, display and position outputs. Also produces the read-side and write-side addressing for the two-bank, 32-line strip VRAM (ping-pong).
- Replaces the separate sync generator and the combinational address math in the top level.
- Downstream consumers:
  - the two VRAM instances, which take bank selects and addresses;
  - the game FSM, which takes write line, column, write enable and frame tick;
  - the colour output mux.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/strip_addr_calc.sv | 19 +
 rtl/vga_strip_timing.sv | 124 ++++++++++++
 tb/tb_vga_strip_timing.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants and the VRAM port bundle.
// Used by vga_strip_timing, strip_addr_calc, the VRAM wrappers and the game FSM.
// Contents:
//   timing localparams and derived totals (H_TOTAL, V_TOTAL, PREFILL)
//   vram_port_t  : {bank, addr, en} for one VRAM access port
//   mul_h_active : constant multiply by H_ACTIVE built from shifts and adds
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int STRIP    = 32;
    // STRIP*H_ACTIVE must fit in ADDR_W bits (20480 <= 32768)
    localparam int ADDR_W   = 15;

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // first vblank line of the prefill window for screen lines 0..STRIP-1
    localparam int PREFILL    = V_TOTAL - STRIP - 1;
    localparam int STRIP_LOG2 = $clog2(STRIP);

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic              en;
    } vram_port_t;

    // Sum of shifted copies of row, one per set bit of H_ACTIVE.
    function automatic logic [ADDR_W-1:0] mul_h_active(input logic [ADDR_W-1:0] row);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (H_ACTIVE[i]) acc = acc + (row << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/strip_addr_calc.sv
// Maps a screen (line, col) to a strip VRAM bank and address.
// Ports:
//   line : low bits of the screen line (strip parity bit + line within strip)
//   col  : pixel column
//   bank : strip parity, selects the ping-pong bank
//   addr : (line mod STRIP)*H_ACTIVE + col, truncated to ADDR_W
module strip_addr_calc
    import vga_timing_pkg::*;
(
    input  logic [STRIP_LOG2:0] line,
    input  logic [9:0]          col,
    output logic                bank,
    output logic [ADDR_W-1:0]   addr
);

    assign bank = line[STRIP_LOG2];
    assign addr = mul_h_active(ADDR_W'(line[STRIP_LOG2-1:0])) + ADDR_W'(col);

endmodule

// File: rtl/vga_strip_timing.sv
// Pixel-rate raster timing for 640x480 VGA with two-bank strip VRAM addressing.
// Every output is a register loaded from the decode of the next (hpos, vpos),
// so all outputs line up with the counters with no skew.
// Ports:
//   clk, reset             : pixel clock, synchronous active-high reset
//   hpos, vpos             : raster counters
//   hsync, vsync           : active-low syncs
//   display_on             : visible area
//   rd_bank, rd_addr       : scan-out side of the strip VRAM
//   wr_en, wr_bank, wr_addr: fill side, one strip ahead of scan-out
//   wr_col, wr_line        : screen pixel being filled
//   frame_tick, strip_tick : single-cycle markers
module vga_strip_timing
    import vga_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [9:0]        hpos,
    output logic [9:0]        vpos,
    output logic              hsync,
    output logic              vsync,
    output logic              display_on,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [9:0]        wr_col,
    output logic [8:0]        wr_line,
    output logic              frame_tick,
    output logic              strip_tick
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WIN_A_END = 10'(V_ACTIVE - STRIP);
    localparam logic [9:0] PRE_START = 10'(PREFILL);
    localparam logic [9:0] PRE_END   = 10'(PREFILL + STRIP);
    localparam logic [9:0] STRIP_W   = 10'(STRIP);

    logic [9:0]        h_nxt;
    logic [9:0]        v_nxt;
    logic              disp_nxt;
    logic              in_a;
    logic              in_b;
    logic              wr_en_nxt;
    logic [8:0]        wr_line_nxt;
    logic              rd_bank_c;
    logic              wr_bank_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [ADDR_W-1:0] wr_addr_c;
    vram_port_t        rd_port;
    vram_port_t        wr_port;

    // Reset forces the decode point to (0,0), so the reset values of every
    // output come out of the same decode logic as normal operation.
    always_comb begin
        h_nxt = hpos + 10'd1;
        v_nxt = vpos;
        if (hpos == H_LAST) begin
            h_nxt = '0;
            v_nxt = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end
        if (reset) begin
            h_nxt = '0;
            v_nxt = '0;
        end
    end

    assign disp_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    // Region A fills one strip ahead of scan-out; region B prefills the
    // first strip of the next frame during vblank.
    assign in_a      = v_nxt < WIN_A_END;
    assign in_b      = (v_nxt >= PRE_START) && (v_nxt < PRE_END);
    assign wr_en_nxt = (h_nxt < H_ACT) && (in_a || in_b);

    always_comb begin
        wr_line_nxt = '0;
        if (wr_en_nxt) begin
            wr_line_nxt = in_a ? 9'(v_nxt + STRIP_W) : 9'(v_nxt - PRE_START);
        end
    end

    strip_addr_calc u_rd_calc (
        .line (v_nxt[STRIP_LOG2:0]),
        .col  (h_nxt),
        .bank (rd_bank_c),
        .addr (rd_addr_c)
    );

    strip_addr_calc u_wr_calc (
        .line (wr_line_nxt[STRIP_LOG2:0]),
        .col  (h_nxt),
        .bank (wr_bank_c),
        .addr (wr_addr_c)
    );

    always_ff @(posedge clk) begin
        hpos       <= h_nxt;
        vpos       <= v_nxt;
        hsync      <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
        vsync      <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
        rd_port    <= '{bank: rd_bank_c, addr: (disp_nxt ? rd_addr_c : '0), en: disp_nxt};
        wr_port    <= '{bank: wr_bank_c, addr: (wr_en_nxt ? wr_addr_c : '0), en: wr_en_nxt};
        wr_col     <= h_nxt;
        wr_line    <= wr_line_nxt;
        frame_tick <= (h_nxt == 10'd0) && (v_nxt == V_ACT);
        strip_tick <= (h_nxt == 10'd0) && (v_nxt[STRIP_LOG2-1:0] == '0) && (v_nxt < V_ACT);
    end

    assign display_on = rd_port.en;
    assign rd_bank    = rd_port.bank;
    assign rd_addr    = rd_port.addr;
    assign wr_en      = wr_port.en;
    assign wr_bank    = wr_port.bank;
    assign wr_addr    = wr_port.addr;

endmodule

// File: tb/tb_vga_strip_timing.sv
module tb_vga_strip_timing;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos, wr_col;
    logic        hsync, vsync, display_on, rd_bank, wr_en, wr_bank;
    logic [14:0] rd_addr, wr_addr;
    logic [8:0]  wr_line;
    logic        frame_tick, strip_tick;

    vga_strip_timing dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_col     (wr_col),
        .wr_line    (wr_line),
        .frame_tick (frame_tick),
        .strip_tick (strip_tick)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [9:0]  hpos;
        logic [9:0]  vpos;
        logic        hsync;
        logic        vsync;
        logic        display_on;
        logic        rd_bank;
        logic [14:0] rd_addr;
        logic        wr_en;
        logic        wr_bank;
        logic [14:0] wr_addr;
        logic [9:0]  wr_col;
        logic [8:0]  wr_line;
        logic        frame_tick;
        logic        strip_tick;
    } obs_t;

    typedef struct {
        int h; int v;
        bit disp; bit hs; bit vs; bit rb; int ra;
        bit en; int wl; bit wb; int wa; bit ft; bit st;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mh, mv;
    int   seg_err = 0;
    int   seg_h, seg_v;
    obs_t seg_got, seg_exp;
    obs_t reset_val;
    vec_t tab[17];
    bit   tab_on = 1'b0;
    int   hs_low, vs_low, ft_cnt, st_cnt;

    // Reference behaviour straight from the raster rules, in plain integer math.
    function automatic obs_t model(input int h, input int v);
        obs_t o;
        int   wl;
        bit   en, disp;
        disp = (h < 640) && (v < 480);
        en = 1'b0;
        wl = 0;
        if (h < 640 && v < 448) begin en = 1'b1; wl = v + 32; end
        if (h < 640 && v >= 492 && v < 524) begin en = 1'b1; wl = v - 492; end
        o.hpos       = 10'(h);
        o.vpos       = 10'(v);
        o.hsync      = !(h >= 656 && h < 752);
        o.vsync      = !(v >= 490 && v < 492);
        o.display_on = disp;
        o.rd_bank    = ((v / 32) % 2) == 1;
        o.rd_addr    = disp ? 15'((v % 32) * 640 + h) : 15'd0;
        o.wr_en      = en;
        o.wr_bank    = ((wl / 32) % 2) == 1;
        o.wr_addr    = en ? 15'((wl % 32) * 640 + h) : 15'd0;
        o.wr_col     = 10'(h);
        o.wr_line    = 9'(wl);
        o.frame_tick = (h == 0) && (v == 480);
        o.strip_tick = (h == 0) && (v % 32 == 0) && (v < 480);
        return o;
    endfunction

    function automatic vec_t mk(input int h, input int v, input bit disp, input bit hs,
                                input bit vs, input bit rb, input int ra, input bit en,
                                input int wl, input bit wb, input int wa, input bit ft,
                                input bit st);
        vec_t t;
        t.h = h; t.v = v; t.disp = disp; t.hs = hs; t.vs = vs; t.rb = rb; t.ra = ra;
        t.en = en; t.wl = wl; t.wb = wb; t.wa = wa; t.ft = ft; t.st = st;
        return t;
    endfunction

    function automatic obs_t sample();
        return {hpos, vpos, hsync, vsync, display_on, rd_bank, rd_addr, wr_en, wr_bank,
                wr_addr, wr_col, wr_line, frame_tick, strip_tick};
    endfunction

    task automatic check_table();
        for (int i = 0; i < 17; i++) begin
            if (tab[i].h == mh && tab[i].v == mv) begin
                n_cmp++;
                if (display_on !== tab[i].disp || hsync !== tab[i].hs || vsync !== tab[i].vs ||
                    rd_bank !== tab[i].rb || int'(rd_addr) != tab[i].ra || wr_en !== tab[i].en ||
                    int'(wr_line) != tab[i].wl || wr_bank !== tab[i].wb ||
                    int'(wr_addr) != tab[i].wa || frame_tick !== tab[i].ft ||
                    strip_tick !== tab[i].st) begin
                    n_bad++;
                    $display("FAIL point(%0d,%0d): got disp=%0b hs=%0b vs=%0b rb=%0b ra=%0d en=%0b wl=%0d wb=%0b wa=%0d ft=%0b st=%0b; need disp=%0b hs=%0b vs=%0b rb=%0b ra=%0d en=%0b wl=%0d wb=%0b wa=%0d ft=%0b st=%0b",
                             mh, mv, display_on, hsync, vsync, rd_bank, rd_addr, wr_en, wr_line,
                             wr_bank, wr_addr, frame_tick, strip_tick, tab[i].disp, tab[i].hs,
                             tab[i].vs, tab[i].rb, tab[i].ra, tab[i].en, tab[i].wl, tab[i].wb,
                             tab[i].wa, tab[i].ft, tab[i].st);
                end
            end
        end
    endtask

    // One clock: advance the expected raster position and compare all outputs.
    task automatic step();
        obs_t got, exp;
        @(posedge clk);
        #1;
        if (reset) begin
            mh = 0; mv = 0;
        end else begin
            mh++;
            if (mh == 800) begin
                mh = 0;
                mv++;
                if (mv == 525) mv = 0;
            end
        end
        got = sample();
        exp = model(mh, mv);
        if (got !== exp) begin
            if (seg_err == 0) begin
                seg_h = mh; seg_v = mv; seg_got = got; seg_exp = exp;
            end
            seg_err++;
        end
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (frame_tick) ft_cnt++;
        if (strip_tick) st_cnt++;
        if (tab_on) check_table();
    endtask

    task automatic close_seg(input string name);
        n_cmp++;
        if (seg_err != 0) begin
            n_bad++;
            $display("FAIL %s: %0d cycle(s) differ from model, first at (%0d,%0d) got %h need %h",
                     name, seg_err, seg_h, seg_v, seg_got, seg_exp);
        end
        seg_err = 0;
    endtask

    task automatic check_int(input string name, input int got, input int need);
        n_cmp++;
        if (got != need) begin
            n_bad++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    initial begin
        reset_val = '{hpos: 10'd0, vpos: 10'd0, hsync: 1'b1, vsync: 1'b1, display_on: 1'b1,
                      rd_bank: 1'b0, rd_addr: 15'd0, wr_en: 1'b1, wr_bank: 1'b1,
                      wr_addr: 15'd0, wr_col: 10'd0, wr_line: 9'd32, frame_tick: 1'b0,
                      strip_tick: 1'b1};

        //            h    v   disp hs vs rb  ra     en wl   wb wa     ft st
        tab[0]  = mk(639,  31, 1, 1, 1, 0, 20479, 1, 63,  1, 20479, 0, 0);
        tab[1]  = mk(0,   447, 1, 1, 1, 1, 19840, 1, 479, 0, 19840, 0, 0);
        tab[2]  = mk(0,   448, 1, 1, 1, 0, 0,     0, 0,   0, 0,     0, 1);
        tab[3]  = mk(5,   492, 0, 1, 1, 1, 0,     1, 0,   0, 5,     0, 0);
        tab[4]  = mk(5,   523, 0, 1, 1, 0, 0,     1, 31,  0, 19845, 0, 0);
        tab[5]  = mk(5,   524, 0, 1, 1, 0, 0,     0, 0,   0, 0,     0, 0);
        tab[6]  = mk(640, 100, 0, 1, 1, 1, 0,     0, 0,   0, 0,     0, 0);
        tab[7]  = mk(0,   480, 0, 1, 1, 1, 0,     0, 0,   0, 0,     1, 0);
        tab[8]  = mk(655,  10, 0, 1, 1, 0, 0,     0, 0,   0, 0,     0, 0);
        tab[9]  = mk(656,  10, 0, 0, 1, 0, 0,     0, 0,   0, 0,     0, 0);
        tab[10] = mk(751,  10, 0, 0, 1, 0, 0,     0, 0,   0, 0,     0, 0);
        tab[11] = mk(752,  10, 0, 1, 1, 0, 0,     0, 0,   0, 0,     0, 0);
        tab[12] = mk(100, 489, 0, 1, 1, 1, 0,     0, 0,   0, 0,     0, 0);
        tab[13] = mk(100, 490, 0, 1, 0, 1, 0,     0, 0,   0, 0,     0, 0);
        tab[14] = mk(100, 491, 0, 1, 0, 1, 0,     0, 0,   0, 0,     0, 0);
        tab[15] = mk(100, 492, 0, 1, 1, 1, 0,     1, 0,   0, 100,   0, 0);
        tab[16] = mk(0,    32, 1, 1, 1, 1, 0,     1, 64,  0, 0,     0, 1);

        // reset state
        reset = 1'b1;
        mh = 0; mv = 0;
        step();
        step();
        n_cmp++;
        if (sample() !== reset_val) begin
            n_bad++;
            $display("FAIL reset_state: got %h need %h", sample(), reset_val);
        end
        close_seg("reset_model");
        reset = 1'b0;

        // one full frame, every cycle against the model, named points from the table
        hs_low = 0; vs_low = 0; ft_cnt = 0; st_cnt = 0;
        tab_on = 1'b1;
        for (int i = 0; i < 800 * 525; i++) begin
            step();
            if (mh == 799) close_seg("frame_line");
        end
        tab_on = 1'b0;
        close_seg("frame_end");
        check_int("hsync_low_cycles", hs_low, 96 * 525);
        check_int("vsync_low_cycles", vs_low, 2 * 800);
        check_int("frame_tick_count", ft_cnt, 1);
        check_int("strip_tick_count", st_cnt, 15);

        // mid-frame reset at (300,250)
        while (!(mh == 300 && mv == 250)) begin
            step();
            if (mh == 799) close_seg("frame2_line");
        end
        close_seg("frame2_tail");
        reset = 1'b1;
        step();
        n_cmp++;
        if (sample() !== reset_val) begin
            n_bad++;
            $display("FAIL midframe_reset: got %h need %h", sample(), reset_val);
        end
        reset = 1'b0;
        repeat (800) step();
        close_seg("after_reset_line");
        check_int("after_reset_vpos", int'(vpos), 1);
        check_int("after_reset_hpos", int'(hpos), 0);

        // random reset pulses
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            step();
            if (i % 100 == 99) close_seg("random_reset");
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
